// File: rtl/flash_prom_pkg.sv
// Shared types and helpers for the flash PROM single-line read buffer.
package flash_prom_pkg;

  localparam int LINE_WORDS = 4;
  localparam int TAG_W      = 14;
  localparam int IDX_W      = 2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOOKUP = 3'd1,
    FILL   = 3'd2,
    SPLIT  = 3'd3,
    RESP   = 3'd4
  } state_t;

  // Byte sel of a little-endian line image (byte 0 = word 0 [7:0]).
  function automatic logic [7:0] line_byte(input logic [LINE_WORDS*16-1:0] line,
                                           input logic [2:0] sel);
    return line[{sel, 3'b000} +: 8];
  endfunction

  // Sign-extend a byte to a 16-bit read result.
  function automatic logic [15:0] sext_byte(input logic [7:0] b);
    return {{8{b[7]}}, b};
  endfunction

endpackage

// File: rtl/flash_prom_line_store.sv
// 4 x 16-bit line storage. One word written per cycle; the read side returns
// the byte at rd_byte and the byte after it, wrapping inside the line so that
// rd_byte = 7 yields byte 7 (lo) and byte 0 (hi).
module flash_prom_line_store
  import flash_prom_pkg::*;
(
  input  logic             sys_clk,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [15:0]      wr_data,
  input  logic [2:0]       rd_byte,
  output logic [7:0]       rd_lo,
  output logic [7:0]       rd_hi
);

  logic [15:0]              words [LINE_WORDS];
  logic [LINE_WORDS*16-1:0] flat;
  logic [2:0]               rd_next;

  // Word write from the flash refill path.
  always_ff @(posedge sys_clk) begin
    if (wr_en) words[wr_idx] <= wr_data;
  end

  // Flatten the words into a byte-addressable line image.
  always_comb begin
    flat = '0;
    for (int i = 0; i < LINE_WORDS; i++) flat[i*16 +: 16] = words[i];
  end

  assign rd_next = rd_byte + 3'd1;
  assign rd_lo   = line_byte(flat, rd_byte);
  assign rd_hi   = line_byte(flat, rd_next);

endmodule

// File: rtl/flash_prom_line_buffer.sv
// Single-line read buffer between the CPU read port and the flash word reader.
//
// Handshakes: the CPU raises cpu_stb with a stable address and holds it until
// the one-cycle cpu_ack pulse, whose cycle also carries cpu_rd_data. Towards
// flash, fl_req is held with a stable fl_addr until the one-cycle fl_ack
// (which carries fl_data); fl_req then drops for exactly one cycle before the
// next word is requested. fl_ack without an outstanding fl_req is ignored.
module flash_prom_line_buffer
  import flash_prom_pkg::*;
(
  input  logic        sys_clk,
  input  logic        reset,
  input  logic        cpu_stb,
  input  logic [16:0] cpu_addr,
  input  logic        cpu_byte_m,
  output logic [15:0] cpu_rd_data,
  output logic        cpu_ack,
  input  logic        inv,
  output logic        fl_req,
  output logic [15:0] fl_addr,
  input  logic [15:0] fl_data,
  input  logic        fl_ack,
  output logic [2:0]  dbg_state
);

  state_t             state, state_nx;
  logic [2:0]         off_q;
  logic               byte_q;
  logic [TAG_W-1:0]   target;
  logic [TAG_W-1:0]   line_tag;
  logic               valid;
  logic               inv_pend;
  logic               split_done;
  logic [7:0]         hold;
  logic [IDX_W-1:0]   wc;
  logic [7:0]         rd_lo, rd_hi;
  logic               hit, is_split, fill_ack, fill_done;
  logic               ack_d;
  logic [15:0]        resp_data;

  assign hit       = valid && (line_tag == target);
  assign is_split  = !byte_q && (off_q == 3'd7);
  assign fill_ack  = (state == FILL) && fl_req && fl_ack;
  assign fill_done = fill_ack && (wc == 2'd3);
  assign dbg_state = state;

  flash_prom_line_store u_store (
    .sys_clk (sys_clk),
    .wr_en   (fill_ack),
    .wr_idx  (wc),
    .wr_data (fl_data),
    .rd_byte (off_q),
    .rd_lo   (rd_lo),
    .rd_hi   (rd_hi)
  );

  // State register.
  always_ff @(posedge sys_clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state decode.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (cpu_stb) state_nx = LOOKUP;
      LOOKUP: begin
        if (!hit)                         state_nx = FILL;
        else if (is_split && !split_done) state_nx = SPLIT;
        else                              state_nx = RESP;
      end
      FILL:    if (fill_done) state_nx = LOOKUP;
      SPLIT:   state_nx = LOOKUP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Response decode: ack is registered on the LOOKUP -> RESP transition.
  // For a split the second line is in the store, so rd_hi is its byte 0.
  always_comb begin
    ack_d = (state == LOOKUP) && hit && !(is_split && !split_done);
    if (byte_q)          resp_data = sext_byte(rd_lo);
    else if (split_done) resp_data = {rd_hi, hold};
    else                 resp_data = {rd_hi, rd_lo};
  end

  // Datapath: request latch, refill sequencing, split hold, invalidation.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      cpu_ack     <= 1'b0;
      cpu_rd_data <= 16'h0000;
      fl_req      <= 1'b0;
      fl_addr     <= 16'h0000;
      valid       <= 1'b0;
      inv_pend    <= 1'b0;
      split_done  <= 1'b0;
      off_q       <= 3'd0;
      byte_q      <= 1'b0;
      target      <= '0;
      line_tag    <= '0;
      hold        <= 8'h00;
      wc          <= '0;
    end else begin
      cpu_ack <= ack_d;
      if (ack_d) cpu_rd_data <= resp_data;
      if (inv && state != IDLE && state != RESP) inv_pend <= 1'b1;
      case (state)
        IDLE: begin
          if (inv) valid <= 1'b0;
          if (cpu_stb) begin
            off_q  <= cpu_addr[2:0];
            byte_q <= cpu_byte_m;
            target <= cpu_addr[16:3];
          end
        end
        LOOKUP: begin
          if (!hit) begin
            wc      <= '0;
            fl_req  <= 1'b1;
            fl_addr <= {target, 2'd0};
          end
        end
        FILL: begin
          if (fill_ack) begin
            fl_req <= 1'b0;
            if (wc == 2'd3) begin
              valid    <= 1'b1;
              line_tag <= target;
            end else begin
              wc      <= wc + 2'd1;
              fl_addr <= {target, wc + 2'd1};
            end
          end else if (!fl_req) begin
            fl_req <= 1'b1;
          end
        end
        SPLIT: begin
          hold       <= rd_lo;
          split_done <= 1'b1;
          target     <= target + 14'd1;
        end
        RESP: begin
          split_done <= 1'b0;
          inv_pend   <= 1'b0;
          if (inv_pend || inv) valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_flash_prom_line_buffer.sv
// Bench for flash_prom_line_buffer: flat flash memory model, CPU read driver,
// expected-value queue checked on every cpu_ack.
module tb_flash_prom_line_buffer;
  import flash_prom_pkg::*;

  logic        sys_clk = 1'b0;
  logic        reset;
  logic        cpu_stb;
  logic [16:0] cpu_addr;
  logic        cpu_byte_m;
  logic [15:0] cpu_rd_data;
  logic        cpu_ack;
  logic        inv;
  logic        fl_req;
  logic [15:0] fl_addr;
  logic [15:0] fl_data;
  logic        fl_ack;
  logic [2:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] flash_mem [65536];
  logic [15:0] exp_q [$];
  logic [15:0] fl_log [$];
  logic [15:0] last_exp;
  int          lat = 3;
  int          ack_cnt = 0;

  flash_prom_line_buffer dut (
    .sys_clk     (sys_clk),
    .reset       (reset),
    .cpu_stb     (cpu_stb),
    .cpu_addr    (cpu_addr),
    .cpu_byte_m  (cpu_byte_m),
    .cpu_rd_data (cpu_rd_data),
    .cpu_ack     (cpu_ack),
    .inv         (inv),
    .fl_req      (fl_req),
    .fl_addr     (fl_addr),
    .fl_data     (fl_data),
    .fl_ack      (fl_ack),
    .dbg_state   (dbg_state)
  );

  // Clock.
  always #5 sys_clk = ~sys_clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] fbyte(input logic [16:0] a);
    logic [15:0] w;
    w = flash_mem[a[16:1]];
    return a[0] ? w[15:8] : w[7:0];
  endfunction

  function automatic logic [15:0] model_read(input logic [16:0] a, input logic bm);
    logic [16:0] a1;
    logic [7:0]  b;
    a1 = a + 17'd1;
    b  = fbyte(a);
    if (bm) return {{8{b[7]}}, b};
    return {fbyte(a1), b};
  endfunction

  // Flash word reader model: ack after lat cycles of fl_req, then expect a gap.
  initial begin
    int cnt;
    logic [15:0] start_addr;
    cnt = 0;
    start_addr = 16'h0;
    fl_ack = 1'b0;
    fl_data = 16'h0;
    forever begin
      @(negedge sys_clk);
      if (fl_ack) begin
        fl_ack = 1'b0;
        cnt = 0;
        check_eq("fl_gap", {31'd0, fl_req}, 32'd0);
      end else if (fl_req) begin
        if (cnt == 0) start_addr = fl_addr;
        cnt++;
        if (cnt >= lat) begin
          fl_ack  = 1'b1;
          fl_data = flash_mem[fl_addr];
          check_eq("fl_addr_stable", {16'd0, fl_addr}, {16'd0, start_addr});
          fl_log.push_back(fl_addr);
          cnt = 0;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Scoreboard: one outstanding read, popped on each ack.
  initial begin
    forever begin
      @(negedge sys_clk);
      if (cpu_ack) begin
        ack_cnt++;
        check_eq("ack_pending", exp_q.size(), 1);
        if (exp_q.size() > 0) begin
          last_exp = exp_q.pop_front();
          check_eq("rd_data", {16'd0, cpu_rd_data}, {16'd0, last_exp});
        end
      end
    end
  end

  task automatic cpu_read(input logic [16:0] a, input logic bm, output int cyc);
    logic got;
    @(negedge sys_clk);
    cpu_addr   = a;
    cpu_byte_m = bm;
    cpu_stb    = 1'b1;
    exp_q.push_back(model_read(a, bm));
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 400) begin
      @(negedge sys_clk);
      cyc++;
      if (cpu_ack) got = 1'b1;
    end
    cpu_stb = 1'b0;
    check_eq("ack_seen", {31'd0, got}, 32'd1);
    if (!got) exp_q.delete();
  endtask

  task automatic pulse_inv();
    @(negedge sys_clk);
    inv = 1'b1;
    @(negedge sys_clk);
    inv = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int w;
    int acks0;
    logic [16:0] ra;
    logic        rb;

    for (int i = 0; i < 65536; i++) flash_mem[i] = 16'($urandom_range(0, 65535));
    flash_mem[16'h2000] = 16'h1100;
    flash_mem[16'h2001] = 16'h3322;
    flash_mem[16'h2002] = 16'h5544;
    flash_mem[16'h2003] = 16'h7766;
    flash_mem[16'h2004] = 16'hA1B2;

    reset = 1'b1; cpu_stb = 1'b0; cpu_addr = '0; cpu_byte_m = 1'b0; inv = 1'b0;
    repeat (3) @(negedge sys_clk);
    check_eq("rst_ack",   {31'd0, cpu_ack}, 32'd0);
    check_eq("rst_data",  {16'd0, cpu_rd_data}, 32'd0);
    check_eq("rst_req",   {31'd0, fl_req}, 32'd0);
    check_eq("rst_faddr", {16'd0, fl_addr}, 32'd0);
    check_eq("rst_state", {29'd0, dbg_state}, {29'd0, IDLE});
    reset = 1'b0;

    // Cold miss then hit.
    lat = 3;
    fl_log.delete();
    cpu_read(17'h04000, 1'b0, cyc);
    check_eq("miss_words", fl_log.size(), 4);
    for (int i = 0; i < 4 && i < fl_log.size(); i++)
      check_eq("miss_addr", {16'd0, fl_log[i]}, 32'h2000 + i);
    repeat (2) @(negedge sys_clk);
    check_eq("rd_hold", {16'd0, cpu_rd_data}, 32'h1100);
    fl_log.delete();
    cpu_read(17'h04002, 1'b0, cyc);
    check_eq("hit_latency", cyc, 2);
    check_eq("hit_no_flash", fl_log.size(), 0);

    // Byte sign extension; inv in IDLE forces a refill.
    flash_mem[16'h2000] = 16'h80FF;
    pulse_inv();
    fl_log.delete();
    cpu_read(17'h04000, 1'b1, cyc);
    check_eq("inv_idle_miss", fl_log.size(), 4);
    cpu_read(17'h04001, 1'b1, cyc);
    flash_mem[16'h2000] = 16'h017F;
    pulse_inv();
    cpu_read(17'h04000, 1'b1, cyc);

    // Unaligned in-line word.
    fl_log.delete();
    cpu_read(17'h04003, 1'b0, cyc);
    check_eq("unaligned_hit", fl_log.size(), 0);

    // Split: first line hit, second line miss.
    fl_log.delete();
    cpu_read(17'h04007, 1'b0, cyc);
    check_eq("split_words", fl_log.size(), 4);
    if (fl_log.size() > 0) check_eq("split_addr", {16'd0, fl_log[0]}, 32'h2004);
    // Split with both lines missing.
    fl_log.delete();
    cpu_read(17'h04007, 1'b0, cyc);
    check_eq("split2_words", fl_log.size(), 8);

    // Split at the top of the address space wraps to flash word 0.
    lat = 1;
    fl_log.delete();
    cpu_read(17'h1FFFF, 1'b0, cyc);
    check_eq("wrap_words", fl_log.size(), 8);
    if (fl_log.size() == 8) begin
      check_eq("wrap_first", {16'd0, fl_log[0]}, 32'hFFFC);
      check_eq("wrap_second", {16'd0, fl_log[4]}, 32'h0000);
    end

    // inv during FILL: data still correct, next same-line read misses.
    lat = 2;
    fl_log.delete();
    w = 0;
    fork
      cpu_read(17'h04010, 1'b0, cyc);
      begin
        while (!fl_req && w < 100) begin
          @(negedge sys_clk);
          w++;
        end
        inv = 1'b1;
        @(negedge sys_clk);
        inv = 1'b0;
      end
    join
    fl_log.delete();
    cpu_read(17'h04012, 1'b0, cyc);
    check_eq("inv_fill_miss", fl_log.size(), 4);

    // Reset after the second word of a fill.
    lat = 3;
    @(negedge sys_clk);
    fl_log.delete();
    acks0 = ack_cnt;
    cpu_addr = 17'h04020; cpu_byte_m = 1'b0; cpu_stb = 1'b1;
    cyc = 0;
    while (fl_log.size() < 2 && cyc < 200) begin
      @(negedge sys_clk);
      cyc++;
    end
    check_eq("rst_fill_progress", fl_log.size(), 2);
    repeat (2) @(negedge sys_clk);
    reset = 1'b1; cpu_stb = 1'b0;
    @(negedge sys_clk);
    check_eq("midrst_req", {31'd0, fl_req}, 32'd0);
    check_eq("midrst_data", {16'd0, cpu_rd_data}, 32'd0);
    check_eq("midrst_state", {29'd0, dbg_state}, {29'd0, IDLE});
    reset = 1'b0;
    repeat (4) @(negedge sys_clk);
    check_eq("midrst_no_ack", ack_cnt, acks0);
    fl_log.delete();
    cpu_read(17'h04020, 1'b0, cyc);
    check_eq("midrst_refill", fl_log.size(), 4);

    // Random reads over a few lines.
    for (int i = 0; i < 24; i++) begin
      ra  = 17'h04000 + 17'($urandom_range(0, 47));
      rb  = 1'($urandom_range(0, 1));
      lat = $urandom_range(1, 4);
      if ($urandom_range(0, 5) == 0) pulse_inv();
      cpu_read(ra, rb, cyc);
    end

    repeat (3) @(negedge sys_clk);
    check_eq("exp_q_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
